mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
Memory-stage load/store engine directly downstream of al_unit. Takes the ALU result as the effective address, plus store data and a memory op from the EX/MEM register. Runs one data-bus transaction over a req/ack handshake, generates byte lanes, and sign- or zero-extends load data. Stalls the pipeline until the transaction completes, and reports misaligned-address and bus-error exceptions.

Parameters:
TIMEOUT_CYCLES, 255, max cycles in REQ without bus_ack before bus_error; 0 disables the timeout.

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous, active-low reset
start  in  1  valid memory op presented this cycle
mem_op  in  3  mem_op_t: MEM_LB, MEM_LBU, MEM_LH, MEM_LHU, MEM_LW, MEM_SB, MEM_SH, MEM_SW
address  in  32  effective byte address (ALU result)
store_data  in  32  rt value for stores
busy  out  1  pipeline stall request
done  out  1  one-cycle completion pulse
load_data  out  32  extended load result, valid while done=1
addr_exception  out  1  misaligned access, valid with done
bus_error  out  1  bus_err or timeout, valid with done
bus_req  out  1  bus request
bus_we  out  1  1 = write
bus_addr  out  32  {address[31:2],2'b00}
bus_be  out  4  byte enables, bit i = byte lane i (little-endian)
bus_wdata  out  32  lane-replicated store data
bus_ack  in  1  transaction complete
bus_rdata  in  32  read word, sampled on ack
bus_err  in  1  error, qualified by bus_ack

Behaviour:
- States: IDLE, REQ, RESP.
- Reset (async, reset_n=0): state=IDLE. busy, done, bus_req, bus_we, addr_exception and bus_error are 0. bus_be=0; load_data, bus_addr and bus_wdata are 0. Reset mid-transaction drops bus_req immediately; there is no completion pulse.
- start is accepted in IDLE or RESP; it is ignored in REQ.
- Accepting a start latches op, address and store_data.
- busy = (state==REQ) | (start & state!=REQ). busy is combinational, so the stall covers the acceptance cycle.
- Alignment check at acceptance:
  - halfword ops are misaligned if address[0]=1;
  - word ops are misaligned if address[1:0]!=0;
  - byte ops are never misaligned.
- Misaligned start: go to RESP, with no bus activity.
- Aligned start: go to REQ. bus_req=1 is registered and first asserted the cycle after acceptance.
- bus_req, bus_we, bus_addr, bus_be and bus_wdata are held stable throughout REQ.
- REQ with bus_ack=1: capture bus_rdata and bus_err, deassert bus_req next cycle, go to RESP.
- REQ timeout counter: cleared on entry to REQ and incremented each REQ cycle without ack.
- Timeout fires when the count reaches TIMEOUT_CYCLES (TIMEOUT_CYCLES!=0): go to RESP with bus_error=1, bus_req drops.
- RESP: done=1 for exactly one cycle, with addr_exception/bus_error as determined. On exception, load_data=0. Next state is REQ if an aligned start arrives, RESP again if a misaligned start arrives, otherwise IDLE.
- Minimum latency for an aligned op: acceptance at cycle 0, bus_req at cycle 1, ack at cycle 1, done at cycle 2.
- Byte enables (loads use the same pattern; bus_we=0):
  - SB: be=1<<a[1:0], wdata={4{sd[7:0]}};
  - SH: be = a[1] ? 4'b1100 : 4'b0011, wdata={2{sd[15:0]}};
  - SW: be=4'b1111, wdata=sd.
- Load extract uses lane a[1:0] for bytes and a[1] for halves:
  - LB and LH sign-extend;
  - LBU and LHU zero-extend;
  - LW passes the word through.
- bus_err asserted without bus_ack is ignored.

Decomposition:
- Package mem_ops_pkg: mem_op_t enum, width constants, and helper functions is_load/is_store/access_size.
- State enum stays local to mem_access_unit.
- One combinational sub-module, load_formatter: inputs rdata, byte offset and op; output is the extended 32-bit load result. It is reused by any future uncached path.

Test Plan:
- SW addr=0x1000, sd=0xDEADBEEF, ack on first req cycle -> bus_addr=0x1000, be=4'b1111, we=1, wdata=0xDEADBEEF; done at cycle 2, no exceptions.
- SB addr=0x2003, sd=0x000000A5 -> be=4'b1000, wdata=0xA5A5A5A5. LB same address with rdata=0x80112233 -> load_data=0xFFFFFF80; LBU -> 0x00000080.
- LH addr=0x3002, rdata=0x8001_7FFF -> be=4'b1100, load_data=0xFFFF8001. LHU addr=0x3000 -> 0x00007FFF.
- LW addr=0x4002 -> no bus_req ever; done and addr_exception=1 the cycle after start, load_data=0.
- TIMEOUT_CYCLES=4, LW with no ack -> bus_req held for 4 cycles then drops, done with bus_error=1. Second run: ack with bus_err=1 -> bus_error=1.
- Back-to-back SW then LW, where the LW start arrives in the RESP cycle -> second req follows with no IDLE gap. reset_n pulled low mid-REQ -> bus_req=0 asynchronously, no done pulse.

Source files
------------

// File: rtl/mem_ops_pkg.sv
// mem_ops_pkg: memory op encoding, bus widths and access-size helpers
package mem_ops_pkg;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BE_W = 4;
  typedef enum logic [2:0] {
    MEM_LB, MEM_LBU, MEM_LH, MEM_LHU, MEM_LW, MEM_SB, MEM_SH, MEM_SW
  } mem_op_t;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;
  function automatic logic is_load(input mem_op_t op);
    return op inside {MEM_LB, MEM_LBU, MEM_LH, MEM_LHU, MEM_LW};
  endfunction
  function automatic logic is_store(input mem_op_t op);
    return op inside {MEM_SB, MEM_SH, MEM_SW};
  endfunction
  function automatic size_t access_size(input mem_op_t op);
    return (op inside {MEM_LB, MEM_LBU, MEM_SB}) ? SZ_B :
           (op inside {MEM_LH, MEM_LHU, MEM_SH}) ? SZ_H : SZ_W;
  endfunction
  function automatic logic misaligned(input mem_op_t op, input logic [1:0] off);
    return access_size(op) == SZ_H ? off[0] : access_size(op) == SZ_W ? |off : 1'b0;
  endfunction
endpackage

// File: rtl/mem_access_unit_load_formatter.sv
// load_formatter: picks the addressed byte/half out of a bus word and extends it
module load_formatter
  import mem_ops_pkg::*;
(
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        offset,
  input  mem_op_t           op,
  output logic [DATA_W-1:0] data
);
  logic [7:0] b;
  logic [15:0] h;
  // lane select then sign/zero extension by op
  always_comb begin
    b = rdata[{offset, 3'b000} +: 8];
    h = offset[1] ? rdata[31:16] : rdata[15:0];
    data = op == MEM_LB  ? {{24{b[7]}}, b} :
           op == MEM_LBU ? {24'b0, b} :
           op == MEM_LH  ? {{16{h[15]}}, h} :
           op == MEM_LHU ? {16'b0, h} : rdata;
  end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: single-transaction load/store engine with stall, alignment and bus-error reporting
module mem_access_unit
  import mem_ops_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  mem_op_t           mem_op,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] store_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] load_data,
  output logic              addr_exception,
  output logic              bus_error,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [BE_W-1:0]   bus_be,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_err
);
  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
  state_t state_q, state_d;
  mem_op_t op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] sd_q, sd_d, rdata_q, rdata_d;
  logic [31:0] cnt_q, cnt_d;
  logic aexc_q, aexc_d, berr_q, berr_d;
  logic accept, timeout;
  size_t sz;
  logic [DATA_W-1:0] fmt;
  // next-state: accept outside REQ, finish REQ on ack or timeout, else fall back to IDLE
  always_comb begin
    state_d = state_q;
    op_d = op_q;
    addr_d = addr_q;
    sd_d = sd_q;
    rdata_d = rdata_q;
    cnt_d = cnt_q;
    aexc_d = aexc_q;
    berr_d = berr_q;
    accept = start && state_q != REQ;
    timeout = TIMEOUT_CYCLES != 0 && cnt_q + 32'd1 == TIMEOUT_CYCLES;
    if (accept) begin
      op_d = mem_op;
      addr_d = address;
      sd_d = store_data;
      aexc_d = misaligned(mem_op, address[1:0]);
      berr_d = 1'b0;
      cnt_d = '0;
      state_d = aexc_d ? RESP : REQ;
    end else if (state_q == REQ) begin
      if (bus_ack) begin
        rdata_d = bus_rdata;
        berr_d = bus_err;
        state_d = RESP;
      end else if (timeout) begin
        berr_d = 1'b1;
        state_d = RESP;
      end else cnt_d = cnt_q + 32'd1;
    end else state_d = IDLE;
  end
  // state and transaction registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      op_q <= MEM_LB;
      addr_q <= '0;
      sd_q <= '0;
      rdata_q <= '0;
      cnt_q <= '0;
      aexc_q <= 1'b0;
      berr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      addr_q <= addr_d;
      sd_q <= sd_d;
      rdata_q <= rdata_d;
      cnt_q <= cnt_d;
      aexc_q <= aexc_d;
      berr_q <= berr_d;
    end
  end
  load_formatter u_fmt (
    .rdata (rdata_q),
    .offset(addr_q[1:0]),
    .op    (op_q),
    .data  (fmt)
  );
  assign sz = access_size(op_q);
  assign busy = state_q == REQ || (start && state_q != REQ);
  assign bus_req = state_q == REQ;
  assign bus_we = bus_req && is_store(op_q);
  assign bus_addr = {addr_q[ADDR_W-1:2], 2'b00};
  assign bus_be = !bus_req ? 4'b0000 :
                  sz == SZ_B ? 4'b0001 << addr_q[1:0] :
                  sz == SZ_H ? (addr_q[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign bus_wdata = sz == SZ_B ? {4{sd_q[7:0]}} : sz == SZ_H ? {2{sd_q[15:0]}} : sd_q;
  assign done = state_q == RESP;
  assign addr_exception = done && aexc_q;
  assign bus_error = done && berr_q;
  assign load_data = (done && !aexc_q && !berr_q && is_load(op_q)) ? fmt : '0;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: scoreboard bench with a scripted bus responder
module tb_mem_access_unit;
  import mem_ops_pkg::*;
  logic clk = 0, reset_n = 0, start = 0;
  mem_op_t mem_op = MEM_LB;
  logic [31:0] address = 0, store_data = 0, bus_rdata = 0;
  logic bus_ack = 0, bus_err = 0;
  logic busy, done, addr_exception, bus_error, bus_req, bus_we;
  logic [31:0] load_data, bus_addr, bus_wdata;
  logic [3:0] bus_be;
  int total = 0, bad = 0;
  typedef struct packed {logic [31:0] ld; logic ae; logic berr; logic chk_ld;} exp_t;
  exp_t sb[$];
  exp_t mon_e;

  mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .mem_op(mem_op), .address(address),
    .store_data(store_data), .busy(busy), .done(done), .load_data(load_data),
    .addr_exception(addr_exception), .bus_error(bus_error), .bus_req(bus_req),
    .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n && done) begin
      if (sb.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        mon_e = sb.pop_front();
        chk("addr_exc", {31'b0, addr_exception}, {31'b0, mon_e.ae});
        chk("bus_error", {31'b0, bus_error}, {31'b0, mon_e.berr});
        if (mon_e.chk_ld) chk("load_data", load_data, mon_e.ld);
      end
    end
  end

  task automatic run(input mem_op_t op, input logic [31:0] a, sd, rd, wd,
                     input logic err, noise, b2b, input int ack_lat, cyc,
                     input logic [3:0] be, input logic [31:0] ld, input logic ae, berr);
    exp_t e;
    int n;
    logic st;
    st = (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
    if (!b2b) begin @(posedge clk); #1; end
    start = 1; mem_op = op; address = a; store_data = sd;
    e.ld = ld; e.ae = ae; e.berr = berr; e.chk_ld = !st;
    sb.push_back(e);
    #1;
    chk("busy_accept", {31'b0, busy}, 1);
    chk("req_accept", {31'b0, bus_req}, 0);
    @(posedge clk); #1;
    start = 0;
    for (n = 0; n < 20; n++) begin
      bus_ack = (n == ack_lat);
      bus_err = (n == ack_lat) ? err : noise;
      bus_rdata = rd;
      @(negedge clk);
      if (!bus_req) break;
      if (n == 0) begin
        chk("bus_we", {31'b0, bus_we}, {31'b0, st});
        chk("bus_addr", bus_addr, {a[31:2], 2'b00});
        chk("bus_be", {28'b0, bus_be}, {28'b0, be});
        chk("busy_req", {31'b0, busy}, 1);
        if (st) chk("bus_wdata", bus_wdata, wd);
      end
      @(posedge clk); #1;
    end
    bus_ack = 0; bus_err = 0;
    chk("req_cycles", n, cyc);
    chk("done_pulse", {31'b0, done}, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    #12;
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_req", {31'b0, bus_req}, 0);
    chk("rst_we", {31'b0, bus_we}, 0);
    chk("rst_be", {28'b0, bus_be}, 0);
    chk("rst_ld", load_data, 0);
    chk("rst_addr", bus_addr, 0);
    chk("rst_wdata", bus_wdata, 0);
    chk("rst_exc", {30'b0, addr_exception, bus_error}, 0);
    @(negedge clk);
    reset_n = 1;
    //  op      addr          sd            rdata         wdata        err noise b2b lat cyc be       ld            ae berr
    run(MEM_SW,  32'h1000, 32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 0, 0, 0,  0, 1, 4'b1111, 32'h0,        0, 0);
    run(MEM_SB,  32'h2003, 32'h000000A5, 32'h0,        32'hA5A5A5A5, 0, 0, 0,  0, 1, 4'b1000, 32'h0,        0, 0);
    run(MEM_LB,  32'h2003, 32'h0,        32'h80112233, 32'h0,        0, 0, 0,  0, 1, 4'b1000, 32'hFFFFFF80, 0, 0);
    run(MEM_LBU, 32'h2003, 32'h0,        32'h80112233, 32'h0,        0, 0, 0,  0, 1, 4'b1000, 32'h00000080, 0, 0);
    run(MEM_LH,  32'h3002, 32'h0,        32'h80017FFF, 32'h0,        0, 0, 0,  0, 1, 4'b1100, 32'hFFFF8001, 0, 0);
    run(MEM_LHU, 32'h3000, 32'h0,        32'h80017FFF, 32'h0,        0, 0, 0,  0, 1, 4'b0011, 32'h00007FFF, 0, 0);
    run(MEM_LW,  32'h4002, 32'h0,        32'h12345678, 32'h0,        0, 0, 0,  0, 0, 4'b0000, 32'h0,        1, 0);
    run(MEM_LW,  32'h5000, 32'h0,        32'h12345678, 32'h0,        0, 0, 0, -1, 4, 4'b1111, 32'h0,        0, 1);
    run(MEM_LW,  32'h5004, 32'h0,        32'h12345678, 32'h0,        1, 0, 0,  1, 2, 4'b1111, 32'h0,        0, 1);
    run(MEM_LW,  32'h5008, 32'h0,        32'h12345678, 32'h0,        0, 1, 0,  2, 3, 4'b1111, 32'h12345678, 0, 0);
    run(MEM_SH,  32'h7001, 32'h0000BEEF, 32'h0,        32'h0,        0, 0, 0,  0, 0, 4'b0000, 32'h0,        1, 0);
    run(MEM_LB,  32'h7001, 32'h0,        32'h00007F00, 32'h0,        0, 0, 0,  0, 1, 4'b0010, 32'h0000007F, 0, 0);
    run(MEM_SH,  32'h7002, 32'h0000BEEF, 32'h0,        32'hBEEFBEEF, 0, 0, 0,  0, 1, 4'b1100, 32'h0,        0, 0);
    run(MEM_SW,  32'h6000, 32'h11223344, 32'h0,        32'h11223344, 0, 0, 0,  0, 1, 4'b1111, 32'h0,        0, 0);
    run(MEM_LW,  32'h6000, 32'h0,        32'hCAFEF00D, 32'h0,        0, 0, 1,  0, 1, 4'b1111, 32'hCAFEF00D, 0, 0);
    @(posedge clk); #1;
    start = 1; mem_op = MEM_LW; address = 32'h8000;
    @(posedge clk); #1;
    start = 0;
    @(negedge clk);
    chk("pre_reset_req", {31'b0, bus_req}, 1);
    #2 reset_n = 0;
    #1;
    chk("async_req_drop", {31'b0, bus_req}, 0);
    chk("async_done", {31'b0, done}, 0);
    chk("async_busy", {31'b0, busy}, 0);
    repeat (2) @(negedge clk);
    reset_n = 1;
    repeat (3) begin
      @(negedge clk);
      chk("post_reset_done", {31'b0, done}, 0);
    end
    chk("post_reset_req", {31'b0, bus_req}, 0);
    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
